// File: rtl/map_checkpoint_ctrl.sv
// Branch checkpoint controller: captures rename-map snapshots per branch, frees them in order,
// and replays the mispredicted branch's snapshot to the map table. Optional stats: CKPT_STATS_EN.
module map_checkpoint_ctrl #(
  parameter  int ARCH_REGS = 64,
  parameter  int PHYS_REGS = 128,
  parameter  int NUM_CKPT  = 4,
  localparam int PW        = $clog2(PHYS_REGS),
  localparam int TAG_W     = $clog2(NUM_CKPT),
  localparam int CNT_W     = $clog2(NUM_CKPT + 1)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [ARCH_REGS-1:0][PW-1:0]  map_snapshot_i,
  input  logic                          br_alloc_i,
  output logic                          br_ready_o,
  output logic [TAG_W-1:0]              br_tag_o,
  input  logic                          resolve_valid_i,
  input  logic [TAG_W-1:0]              resolve_tag_i,
  input  logic                          resolve_mispred_i,
  input  logic                          flush_i,
  output logic                          restore_valid_o,
  output logic [ARCH_REGS-1:0][PW-1:0]  restore_data_o,
  output logic [CNT_W-1:0]              count_o,
  output logic                          stall_o
`ifdef CKPT_STATS_EN
  ,
  output logic [31:0]                   mispred_count_o,
  output logic [31:0]                   full_stall_cycles_o
`endif
);

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [TAG_W:0]                 head_reg, head_next;
  logic [TAG_W:0]                 tail_reg, tail_next;
  logic [NUM_CKPT-1:0]            valid_reg, valid_next;
  logic [NUM_CKPT-1:0]            resolved_reg, resolved_next;
  logic                           restore_valid_reg;
  logic [ARCH_REGS-1:0][PW-1:0]   restore_data_reg;
  logic [ARCH_REGS-1:0][PW-1:0]   snap_mem [NUM_CKPT];

  logic [TAG_W-1:0] head_idx;
  logic [TAG_W-1:0] tail_idx;
  logic [TAG_W-1:0] mis_dist;
  logic             full;
  logic             res_hit;
  logic             mispred;
  logic             resolve_ok;
  logic             retire;
  logic             alloc_fire;

  assign head_idx = head_reg[TAG_W-1:0];
  assign tail_idx = tail_reg[TAG_W-1:0];
  assign full     = (head_idx == tail_idx) && (head_reg[TAG_W] != tail_reg[TAG_W]);

  assign br_ready_o      = !full;
  assign br_tag_o        = tail_idx;
  assign count_o         = CNT_W'(tail_reg - head_reg);
  assign restore_valid_o = restore_valid_reg;
  assign restore_data_o  = restore_data_reg;
  assign stall_o         = full || restore_valid_reg;

  // Resolves to slots that are not live are dropped entirely.
  assign res_hit    = resolve_valid_i && valid_reg[resolve_tag_i];
  assign mispred    = res_hit && resolve_mispred_i && !flush_i;
  assign resolve_ok = res_hit && !resolve_mispred_i && !flush_i;
  assign mis_dist   = resolve_tag_i - head_idx;

  // Head may still retire under a mispredict as long as it is not the squashed slot itself.
  assign retire     = valid_reg[head_idx] && resolved_reg[head_idx] && !flush_i &&
                      !(mispred && (resolve_tag_i == head_idx));
  assign alloc_fire = br_alloc_i && !full && !flush_i && !mispred;

  generate
    for (genvar gi = 0; gi < NUM_CKPT; gi++) begin : g_slot
      logic [TAG_W-1:0] age;
      logic             squash;
      logic             set_alloc;

      // age = position of this slot relative to the oldest live checkpoint
      assign age       = TAG_W'(gi) - head_idx;
      assign squash    = (mispred && (age >= mis_dist)) ||
                         (retire && (head_idx == TAG_W'(gi)));
      assign set_alloc = alloc_fire && (tail_idx == TAG_W'(gi));

      assign valid_next[gi]    = !flush_i && (set_alloc || (valid_reg[gi] && !squash));
      assign resolved_next[gi] = !flush_i && !set_alloc && !squash &&
                                 (resolved_reg[gi] ||
                                  (resolve_ok && (resolve_tag_i == TAG_W'(gi))));
    end
  endgenerate

  always_comb begin
    head_next = head_reg;
    tail_next = tail_reg;
    if (flush_i) begin
      head_next = '0;
      tail_next = '0;
    end else begin
      if (retire) begin
        head_next = head_reg + (TAG_W + 1)'(1);
      end
      if (mispred) begin
        tail_next = head_reg + {1'b0, mis_dist};
      end else if (alloc_fire) begin
        tail_next = tail_reg + (TAG_W + 1)'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_reg          <= '0;
      tail_reg          <= '0;
      valid_reg         <= '0;
      resolved_reg      <= '0;
      restore_valid_reg <= 1'b0;
    end else begin
      head_reg          <= head_next;
      tail_reg          <= tail_next;
      valid_reg         <= valid_next;
      resolved_reg      <= resolved_next;
      restore_valid_reg <= mispred;
    end
  end

  // Snapshot storage has no reset so it maps onto block RAM.
  always_ff @(posedge clock) begin
    if (alloc_fire) begin
      snap_mem[tail_idx] <= map_snapshot_i;
    end
  end

  // Registered read port; the restored mapping persists until the next mispredict.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      restore_data_reg <= '0;
    end else if (mispred) begin
      restore_data_reg <= snap_mem[resolve_tag_i];
    end
  end

`ifdef CKPT_STATS_EN
  logic [31:0] mispred_count_reg;
  logic [31:0] full_stall_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mispred_count_reg <= '0;
      full_stall_reg    <= '0;
    end else begin
      if (mispred && (mispred_count_reg != 32'hFFFF_FFFF)) begin
        mispred_count_reg <= mispred_count_reg + 32'd1;
      end
      if (br_alloc_i && full && (full_stall_reg != 32'hFFFF_FFFF)) begin
        full_stall_reg <= full_stall_reg + 32'd1;
      end
    end
  end

  assign mispred_count_o     = mispred_count_reg;
  assign full_stall_cycles_o = full_stall_reg;
`endif

endmodule

// File: tb/tb_map_checkpoint_ctrl.sv
// Self-checking bench for map_checkpoint_ctrl: directed test-plan steps followed by random
// traffic, all compared against a queue-based model of the live checkpoints.
module tb_map_checkpoint_ctrl;
  localparam int ARCH = 64;
  localparam int PHYS = 128;
  localparam int N    = 4;
  localparam int PW   = 7;
  localparam int TW   = 2;
  localparam int CW   = 3;

  typedef logic [ARCH-1:0][PW-1:0] snap_t;
  typedef struct {
    bit    res;
    snap_t snap;
  } ent_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  snap_t         map_snapshot_i = '0;
  logic          br_alloc_i = 1'b0;
  logic          br_ready_o;
  logic [TW-1:0] br_tag_o;
  logic          resolve_valid_i = 1'b0;
  logic [TW-1:0] resolve_tag_i = '0;
  logic          resolve_mispred_i = 1'b0;
  logic          flush_i = 1'b0;
  logic          restore_valid_o;
  snap_t         restore_data_o;
  logic [CW-1:0] count_o;
  logic          stall_o;
`ifdef CKPT_STATS_EN
  logic [31:0]   mispred_count_o;
  logic [31:0]   full_stall_cycles_o;
`endif

  map_checkpoint_ctrl #(.ARCH_REGS(ARCH), .PHYS_REGS(PHYS), .NUM_CKPT(N)) dut (
    .clock             (clock),
    .reset             (reset),
    .map_snapshot_i    (map_snapshot_i),
    .br_alloc_i        (br_alloc_i),
    .br_ready_o        (br_ready_o),
    .br_tag_o          (br_tag_o),
    .resolve_valid_i   (resolve_valid_i),
    .resolve_tag_i     (resolve_tag_i),
    .resolve_mispred_i (resolve_mispred_i),
    .flush_i           (flush_i),
    .restore_valid_o   (restore_valid_o),
    .restore_data_o    (restore_data_o),
    .count_o           (count_o),
    .stall_o           (stall_o)
`ifdef CKPT_STATS_EN
    ,
    .mispred_count_o     (mispred_count_o),
    .full_stall_cycles_o (full_stall_cycles_o)
`endif
  );

  always #5 clock = ~clock;

  // Reference model: live checkpoints oldest-first; tag of entry i is (mhead + i) % N.
  ent_t        q[$];
  int          mhead;
  bit          m_rv;
  snap_t       m_rd;
  int unsigned m_mis;
  int unsigned m_fst;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    mhead = 0;
    m_rv  = 1'b0;
    m_rd  = '0;
    m_mis = 0;
    m_fst = 0;
  endtask

  task automatic compare_all();
    int sz;
    sz = q.size();
    chk("count", count_o, sz);
    chk("br_ready", br_ready_o, sz < N);
    chk("br_tag", br_tag_o, (mhead + sz) % N);
    chk("restore_valid", restore_valid_o, m_rv);
    chk("restore_data", restore_data_o, m_rd);
    chk("stall", stall_o, (sz == N) || m_rv);
`ifdef CKPT_STATS_EN
    chk("mispred_count", mispred_count_o, m_mis);
    chk("full_stall_cycles", full_stall_cycles_o, m_fst);
`endif
  endtask

  // Applies one clock edge's worth of the rules to the model, from the driven inputs.
  task automatic model_step();
    int sz;
    int k;
    bit hit;
    bit full;
    bit ret;
    sz   = q.size();
    full = (sz == N);
    if (br_alloc_i && full && m_fst != 32'hFFFF_FFFF) m_fst++;
    if (flush_i) begin
      q.delete();
      mhead = 0;
      m_rv  = 1'b0;
      return;
    end
    k   = (int'(resolve_tag_i) - mhead + N) % N;
    hit = resolve_valid_i && (k < sz);
    if (hit && resolve_mispred_i) begin
      m_rv = 1'b1;
      m_rd = q[k].snap;
      if (m_mis != 32'hFFFF_FFFF) m_mis++;
      while (q.size() > k) void'(q.pop_back());
      if (k > 0 && q[0].res) begin
        void'(q.pop_front());
        mhead = (mhead + 1) % N;
      end
    end else begin
      ret  = (sz > 0) && q[0].res;
      m_rv = 1'b0;
      if (hit) q[k].res = 1'b1;
      if (br_alloc_i && !full) q.push_back('{res: 1'b0, snap: map_snapshot_i});
      if (ret) begin
        void'(q.pop_front());
        mhead = (mhead + 1) % N;
      end
    end
  endtask

  task automatic cyc(input bit a, input bit rv, input int rt, input bit rm, input bit fl,
                     input snap_t s);
    br_alloc_i        = a;
    resolve_valid_i   = rv;
    resolve_tag_i     = TW'(rt);
    resolve_mispred_i = rm;
    flush_i           = fl;
    map_snapshot_i    = s;
    @(posedge clock);
    model_step();
    @(negedge clock);
    compare_all();
  endtask

  function automatic snap_t mk(input int v);
    snap_t s;
    s    = '0;
    s[1] = PW'(v);
    return s;
  endfunction

  function automatic snap_t rnd_snap();
    snap_t s;
    for (int i = 0; i < ARCH; i++) s[i] = PW'($urandom);
    return s;
  endfunction

  initial begin
    model_reset();
    repeat (2) @(negedge clock);
    compare_all();
    reset = 1'b0;
    @(negedge clock);
    compare_all();
    chk("tp_reset_count", count_o, 0);
    chk("tp_reset_tag", br_tag_o, 0);

    // Fill all four slots; arch 1 maps to 64+k in snapshot k.
    for (int k = 0; k < N; k++) begin
      chk("tp_alloc_tag", br_tag_o, k);
      cyc(1, 0, 0, 0, 0, mk(64 + k));
    end
    chk("tp_full_count", count_o, 4);
    chk("tp_full_ready", br_ready_o, 0);
    chk("tp_full_stall", stall_o, 1);
    cyc(1, 0, 0, 0, 0, mk(99));
    chk("tp_fifth_ignored", count_o, 4);

    // Mispredict tag 1 from full.
    cyc(0, 1, 1, 1, 0, '0);
    chk("tp_mis_pulse", restore_valid_o, 1);
    chk("tp_mis_phys", restore_data_o[1], 65);
    chk("tp_mis_count", count_o, 1);
    chk("tp_mis_tag", br_tag_o, 1);
    chk("tp_mis_stall", stall_o, 1);
    cyc(0, 0, 0, 0, 0, '0);
    chk("tp_pulse_one_cycle", restore_valid_o, 0);
    chk("tp_restore_hold", restore_data_o[1], 65);

    // Out-of-order resolves drain in order.
    cyc(0, 0, 0, 0, 1, '0);
    for (int k = 0; k < 3; k++) cyc(1, 0, 0, 0, 0, mk(10 + k));
    cyc(0, 1, 2, 0, 0, '0);
    chk("tp_ooo_hold3", count_o, 3);
    cyc(0, 1, 0, 0, 0, '0);
    cyc(0, 0, 0, 0, 0, '0);
    chk("tp_retire0", count_o, 2);
    cyc(0, 1, 1, 0, 0, '0);
    cyc(0, 0, 0, 0, 0, '0);
    chk("tp_retire1", count_o, 1);
    cyc(0, 0, 0, 0, 0, '0);
    chk("tp_retire2", count_o, 0);

    // Alloc collides with mispredict of the head.
    cyc(0, 0, 0, 0, 1, '0);
    cyc(1, 0, 0, 0, 0, mk(20));
    cyc(1, 0, 0, 0, 0, mk(21));
    cyc(1, 1, 0, 1, 0, mk(22));
    chk("tp_drop_count", count_o, 0);
    chk("tp_drop_tail", br_tag_o, 0);
    chk("tp_drop_pulse", restore_valid_o, 1);
    chk("tp_drop_phys", restore_data_o[1], 20);

    // Flush beats mispredict.
    for (int k = 0; k < 3; k++) cyc(1, 0, 0, 0, 0, mk(30 + k));
    cyc(0, 1, 1, 1, 1, '0);
    chk("tp_flush_count", count_o, 0);
    chk("tp_flush_nopulse", restore_valid_o, 0);

    // Asynchronous reset in the middle of an allocation.
    cyc(1, 0, 0, 0, 0, mk(40));
    br_alloc_i     = 1'b1;
    map_snapshot_i = mk(41);
    #2 reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    chk("tp_async_count", count_o, 0);
    @(negedge clock);
    br_alloc_i = 1'b0;
    compare_all();
    reset = 1'b0;

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      bit a, rv, rm, fl;
      a  = ($urandom_range(0, 99) < 55);
      rv = ($urandom_range(0, 99) < 45);
      rm = ($urandom_range(0, 99) < 25);
      fl = ($urandom_range(0, 99) < 3);
      cyc(a, rv, int'($urandom_range(0, N - 1)), rm, fl, rnd_snap());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/map_checkpoint_ctrl.md
Name: map_checkpoint_ctrl

Overview:
Branch checkpoint controller for the rename map table. On branch dispatch it captures the map table's snapshot and returns a branch tag. It frees checkpoints in order as branches resolve. On a mispredict it squashes the mispredicted checkpoint and all younger ones, then drives a one-cycle restore pulse plus the saved mapping into the map table's snapshot_restore_i and snapshot_data_i.

Parameters:
ARCH_REGS, 64, number of architectural registers
PHYS_REGS, 128, number of physical registers (tag width = $clog2(PHYS_REGS))
NUM_CKPT, 4, checkpoint slots; power of two, >= 2; TAG_W = $clog2(NUM_CKPT)

Ports:
clock  in  1  clock
reset  in  1  asynchronous, active-high reset
map_snapshot_i  in  ARCH_REGS x $clog2(PHYS_REGS)  current map table contents
br_alloc_i  in  1  branch dispatching this cycle; requests a checkpoint
br_ready_o  out  1  a checkpoint slot is free
br_tag_o  out  TAG_W  tag assigned to an allocation this cycle
resolve_valid_i  in  1  branch resolution
resolve_tag_i  in  TAG_W  tag of the resolving branch
resolve_mispred_i  in  1  1 = mispredicted, 0 = correct
flush_i  in  1  full pipeline flush
restore_valid_o  out  1  restore pulse to map table
restore_data_o  out  ARCH_REGS x $clog2(PHYS_REGS)  mapping to restore
count_o  out  $clog2(NUM_CKPT+1)  live checkpoints
stall_o  out  1  dispatch must hold (full, or restore cycle)

Behaviour:
- Single clock domain. reset is asynchronous and active-high.
- Reset state: head = tail = 0, all slots invalid and unresolved. Outputs: count_o = 0, br_ready_o = 1, br_tag_o = 0, restore_valid_o = 0, restore_data_o = all 0, stall_o = 0.
- Storage is a circular buffer in program order. Each slot holds: valid, resolved, snapshot. head = oldest slot; tail = next slot to allocate.
- br_ready_o = (count_o < NUM_CKPT). It depends on registered state only; a same-cycle free does not enable allocation.
- br_tag_o = tail. This output is combinational.
- Allocate: when br_alloc_i && br_ready_o, write map_snapshot_i into slot tail, set valid = 1 and resolved = 0, and advance tail.
- br_alloc_i while full is ignored.
- Correct resolve: the addressed slot's resolved bit is set to 1. A resolve to an invalid slot is ignored.
- Retire: each cycle, if slot head is valid and resolved, clear it, advance head and decrement count. At most one retire per cycle; out-of-order resolves drain over successive cycles.
- Mispredict (resolve_valid_i && resolve_mispred_i, target slot valid):
  - Invalidate slot t and every younger slot up to tail, and set tail = t.
  - count becomes the distance from head to t (0 when t == head).
  - Next cycle: restore_valid_o = 1 for exactly one cycle and restore_data_o = snapshot[t]. restore_data_o holds its value until the next restore.
  - stall_o = 1 in the cycle restore_valid_o is high.
  - A mispredict to an invalid slot is ignored.
- Priority: flush_i > mispredict > retire/allocate.
  - An alloc in a mispredict cycle is dropped.
  - A retire of head in a mispredict cycle still occurs if head is older than t.
- flush_i: all slots invalid, head = tail = 0, count = 0. No restore pulse; the map table's own flush handles identity mapping. A pending restore pulse scheduled for the next cycle is cancelled.
- stall_o = !br_ready_o || restore_valid_o.
- Pointers carry a wrap bit. Full = (indexes equal && wrap bits differ). Count arithmetic is modulo 2*NUM_CKPT.
- Reset asserted mid-operation clears everything immediately, with no restore pulse.

Optional Feature:
Macro CKPT_STATS_EN.
- Defined: adds 32-bit saturating outputs mispred_count_o and full_stall_cycles_o.
  - mispred_count_o increments on each accepted mispredict.
  - full_stall_cycles_o increments each cycle with br_alloc_i && !br_ready_o.
  - Both counters reset to 0 on reset only; flush_i does not clear them.
- Undefined: these ports and counters are absent. All other behaviour is identical.

Test Plan:
- Reset -> count_o = 0, br_ready_o = 1, br_tag_o = 0, restore_valid_o = 0, stall_o = 0.
- Four allocs, snapshot k mapping arch 1 -> phys 64+k -> tags 0, 1, 2, 3; count_o = 4; br_ready_o = 0, stall_o = 1. A fifth alloc is ignored and count stays 4.
- From the full state, mispredict tag 1 -> next cycle restore_valid_o = 1 for one cycle with restore_data_o[1] = 65; count_o = 1; br_tag_o = 1.
- Three allocs (tags 0-2). Resolve tag 2 correct -> count stays 3. Resolve tag 0 -> count 2 next cycle. Resolve tag 1 -> count 1, then 0 on successive cycles.
- Same cycle br_alloc_i = 1 and mispredict tag 0 with 2 live -> alloc dropped; count_o = 0; tail = 0; restore pulse next cycle.
- With 3 live, flush_i together with a mispredict -> count_o = 0, no restore_valid_o pulse. Reset asserted mid-allocation -> all outputs at reset values immediately.
